neo_dtack_gen: RTL and testbench

Parametrised 68k bus-cycle acknowledge generator for the NeoGeo system bus. It replaces the fixed-zone wait logic with N decoded zones, each with its own wait-state count and external wait/acknowledge options. It adds a bus-error watchdog and multi-zone decode error reporting. It sits beside the address decoder: it consumes the active-low zone selects and nAS, and drives nDTACK and nBERR to the CPU.

---
 rtl/neo_dtack_pkg.sv | 39 +++
 rtl/neo_dtack_wd.sv | 31 +++
 rtl/neo_dtack_gen.sv | 139 +++++++++++++
 tb/tb_neo_dtack_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/neo_dtack_pkg.sv
// Shared types and helpers for the 68k DTACK/BERR generator.
// Zone priority is lowest index first; select vectors wider than MAXZ are not supported.
package neo_dtack_pkg;

    localparam int DEF_NZONES  = 8;
    localparam int DEF_WAITW   = 3;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_WDW     = 8;
    localparam int MAXZ        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD,
        ST_ACK,
        ST_BERR
    } state_t;

    typedef struct packed {
        logic [4:0] idx;
        logic       hit;
        logic       multi;
    } prio_t;

    // Descending scan: the final match is the lowest index, any earlier match flags a collision.
    function automatic prio_t zone_prio(input logic [MAXZ-1:0] nzone);
        prio_t r;
        r = '0;
        for (int i = MAXZ - 1; i >= 0; i--) begin
            if (!nzone[i]) begin
                if (r.hit) r.multi = 1'b1;
                r.hit = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neo_dtack_wd.sv
// Bus-cycle watchdog: counts enabled edges, expire_o is combinational on the edge the count reaches TIMEOUT.
// No backpressure; clr_i has priority over en_i and TIMEOUT=0 never expires.
module neo_dtack_wd #(
    parameter int TIMEOUT = 64,
    parameter int WDW     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WDW-1:0] LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/neo_dtack_gen.sv
// 68k DTACK/BERR generator: N prioritised zones, per-zone wait count, external wait/ack, watchdog.
// nDTACK falls after edge E0+W with no external wait; stalls on nEXTWAIT low or PDTACK low (ext zones).
module neo_dtack_gen
    import neo_dtack_pkg::*;
#(
    parameter int NZONES  = DEF_NZONES,
    parameter int WAITW   = DEF_WAITW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int WDW     = DEF_WDW
) (
    input  logic                    CLK_68KCLK,
    input  logic                    RESET,
    input  logic                    nAS,
    input  logic [NZONES-1:0]       nZONE,
    input  logic [NZONES*WAITW-1:0] ZONE_WAIT,
    input  logic [NZONES-1:0]       ZONE_EXT,
    input  logic [NZONES-1:0]       nEXTWAIT,
    input  logic                    PDTACK,
    output logic                    nDTACK,
    output logic                    nBERR,
    output logic                    ZONE_ERR,
    output logic                    BUSY
);

    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;

    state_t           state_q, state_d;
    logic [WAITW-1:0] cnt_q, cnt_d;
    logic [ZW-1:0]    zone_q, zone_d;
    logic             unmapped_q, unmapped_d;
    logic             armed_q;
    logic             zone_err_d;
    logic             ndtack_q, nberr_q, zone_err_q, busy_q;

    logic [MAXZ-1:0]  nzone_pad;
    prio_t            prio;
    logic [ZW-1:0]    prio_zone;
    logic [WAITW-1:0] wait_e0;
    logic             e0, ready_e0, ready_cur;
    logic             wd_en, wd_clr, wd_exp;

    always_comb begin
        nzone_pad             = '1;
        nzone_pad[NZONES-1:0] = nZONE;
    end

    assign prio      = zone_prio(nzone_pad);
    assign prio_zone = ZW'(prio.idx);
    assign wait_e0   = ZONE_WAIT[prio_zone*WAITW +: WAITW];

    assign e0        = (state_q == ST_IDLE) && armed_q && !nAS;
    assign ready_e0  = nEXTWAIT[prio_zone] && (!ZONE_EXT[prio_zone] || PDTACK);
    assign ready_cur = !unmapped_q && nEXTWAIT[zone_q] && (!ZONE_EXT[zone_q] || PDTACK);

    // Counting stops on the abort edge too, so a cycle straight after an abort starts from zero.
    assign wd_en  = e0 || (((state_q == ST_COUNT) || (state_q == ST_HOLD)) && !nAS);
    assign wd_clr = !wd_en;

    neo_dtack_wd #(
        .TIMEOUT (TIMEOUT),
        .WDW     (WDW)
    ) u_wd (
        .clk_i    (CLK_68KCLK),
        .rst_i    (RESET),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_exp)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        zone_d     = zone_q;
        unmapped_d = unmapped_q;
        zone_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (e0) begin
                    zone_d     = prio_zone;
                    unmapped_d = !prio.hit;
                    zone_err_d = prio.multi;
                    cnt_d      = prio.hit ? wait_e0 : '0;
                    if (!prio.hit)            state_d = wd_exp ? ST_BERR : ST_HOLD;
                    else if (wait_e0 != '0)   state_d = wd_exp ? ST_BERR : ST_COUNT;
                    else if (ready_e0)        state_d = ST_ACK;
                    else                      state_d = wd_exp ? ST_BERR : ST_HOLD;
                end
            end
            ST_COUNT: begin
                if (nAS) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAITW'(1)) state_d = ready_cur ? ST_ACK : (wd_exp ? ST_BERR : ST_HOLD);
                    else if (wd_exp)        state_d = ST_BERR;
                end
            end
            ST_HOLD: begin
                if (nAS)            state_d = ST_IDLE;
                else if (ready_cur) state_d = ST_ACK;
                else if (wd_exp)    state_d = ST_BERR;
            end
            ST_ACK, ST_BERR: begin
                if (nAS) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_68KCLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            zone_q     <= '0;
            unmapped_q <= 1'b0;
            armed_q    <= 1'b0;
            ndtack_q   <= 1'b1;
            nberr_q    <= 1'b1;
            zone_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zone_q     <= zone_d;
            unmapped_q <= unmapped_d;
            armed_q    <= armed_q | nAS;
            ndtack_q   <= (state_d != ST_ACK);
            nberr_q    <= (state_d != ST_BERR);
            zone_err_q <= zone_err_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign nDTACK   = ndtack_q;
    assign nBERR    = nberr_q;
    assign ZONE_ERR = zone_err_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_neo_dtack_gen.sv
// Bench for neo_dtack_gen: directed scenarios then random bus cycles against a per-cycle timing model.
module tb_neo_dtack_gen;

    localparam int NZ  = 8;
    localparam int WW  = 3;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          RESET;
    logic          nAS;
    logic [NZ-1:0] nZONE;
    logic [NZ*WW-1:0] ZONE_WAIT;
    logic [NZ-1:0] ZONE_EXT;
    logic [NZ-1:0] nEXTWAIT;
    logic          PDTACK;
    logic          nDTACK, nBERR, ZONE_ERR, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    neo_dtack_gen #(
        .NZONES  (NZ),
        .WAITW   (WW),
        .TIMEOUT (TMO),
        .WDW     (8)
    ) dut (
        .CLK_68KCLK (clk),
        .RESET      (RESET),
        .nAS        (nAS),
        .nZONE      (nZONE),
        .ZONE_WAIT  (ZONE_WAIT),
        .ZONE_EXT   (ZONE_EXT),
        .nEXTWAIT   (nEXTWAIT),
        .PDTACK     (PDTACK),
        .nDTACK     (nDTACK),
        .nBERR      (nBERR),
        .ZONE_ERR   (ZONE_ERR),
        .BUSY       (BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NZ*WW-1:0] zw_set(input int z, input int w);
        logic [NZ*WW-1:0] r;
        r = '0;
        r[z*WW +: WW] = WW'(w);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle. Offsets k are edges after E0 (k=0 is E0). The expected acknowledge edge is
    // max(wait count, first edge the zone is ready); the bus error edge is TMO-1; nAS high ends it.
    task automatic run_txn(input logic [NZ-1:0] nz, input logic [NZ*WW-1:0] zw,
                           input logic [NZ-1:0] zext, input int ext_rel, input int pd_rel,
                           input int abort_at, input int hold);
        int z, w, tr, a, ev, r;
        bit hit, multi, is_ack, aborted;
        logic [NZ-1:0] ext_bg;
        z = 0; hit = 0; multi = 0;
        for (int i = NZ - 1; i >= 0; i--) begin
            if (!nz[i]) begin
                if (hit) multi = 1;
                hit = 1;
                z = i;
            end
        end
        w  = hit ? int'(zw[z*WW +: WW]) : 0;
        tr = ext_rel;
        if (zext[z] && pd_rel > tr) tr = pd_rel;
        a       = hit ? ((w > tr) ? w : tr) : 1000;
        is_ack  = (a <= TMO - 1);
        ev      = is_ack ? a : TMO - 1;
        r       = (abort_at > 0) ? abort_at : ev + 1 + hold;
        aborted = (r <= ev);
        ext_bg  = NZ'($urandom);
        ZONE_WAIT = zw;
        ZONE_EXT  = zext;
        for (int k = 0; k <= r + 1; k++) begin
            nAS      = (k >= r);
            nZONE    = (k == 0) ? nz : NZ'($urandom);
            nEXTWAIT = ext_bg;
            nEXTWAIT[z] = (k >= ext_rel);
            PDTACK   = (k >= pd_rel);
            if (k > 0) ZONE_WAIT = (NZ*WW)'($urandom);
            step();
            chk("ndtack", nDTACK, !(!aborted && is_ack && k >= ev && k < r));
            chk("nberr", nBERR, !(!aborted && !is_ack && k >= ev && k < r));
            chk("busy", BUSY, (k < r));
            chk("zone_err", ZONE_ERR, (k == 0) && multi);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [NZ-1:0] nz;
        int sel, a, b, ext_rel, pd_rel, abort_at;

        RESET = 1'b1; nAS = 1'b0; nZONE = 8'hFB; ZONE_WAIT = '0;
        ZONE_EXT = '0; nEXTWAIT = '1; PDTACK = 1'b0;
        repeat (2) begin
            step();
            chk("rst_ndtack", nDTACK, 1'b1);
            chk("rst_nberr", nBERR, 1'b1);
            chk("rst_zone_err", ZONE_ERR, 1'b0);
            chk("rst_busy", BUSY, 1'b0);
        end
        // Strobe already low when reset drops: must be ignored until nAS is seen high.
        RESET = 1'b0;
        repeat (3) begin
            step();
            chk("unarmed_busy", BUSY, 1'b0);
            chk("unarmed_ndtack", nDTACK, 1'b1);
        end
        nAS = 1'b1;
        step();

        // Reset in the middle of a counted cycle.
        nAS = 1'b0; nZONE = ~8'h20; ZONE_WAIT = zw_set(5, 5);
        step();
        chk("cnt_busy", BUSY, 1'b1);
        step();
        chk("cnt_ndtack", nDTACK, 1'b1);
        RESET = 1'b1;
        step();
        chk("midrst_busy", BUSY, 1'b0);
        RESET = 1'b0;
        repeat (6) begin
            step();
            chk("postrst_busy", BUSY, 1'b0);
            chk("postrst_ndtack", nDTACK, 1'b1);
        end
        nAS = 1'b1;
        step();

        run_txn(~8'h04, zw_set(2, 0), 8'h00, 0, 0, 0, 2);
        run_txn(~8'h20, zw_set(5, 3), 8'h00, 0, 0, 0, 1);
        run_txn(~8'h02, zw_set(1, 1), 8'h02, 0, 5, 0, 1);
        run_txn(~8'h02, zw_set(1, 1), 8'h02, 4, 0, 0, 1);
        run_txn(8'hFF, '0, 8'h00, 0, 0, 0, 1);
        run_txn(~8'h48, zw_set(6, 4), 8'h00, 0, 0, 0, 1);
        run_txn(~8'h20, zw_set(5, 3), 8'h00, 0, 0, 2, 0);
        run_txn(~8'h10, zw_set(4, 2), 8'h10, 0, TMO - 1, 0, 0);
        run_txn(~8'h10, zw_set(4, 2), 8'h10, 0, TMO, 0, 0);

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, NZ - 1);
            b   = $urandom_range(0, NZ - 1);
            if (sel == 0)     nz = 8'hFF;
            else if (sel < 3) nz = ~((8'h01 << a) | (8'h01 << b));
            else              nz = ~(8'h01 << a);
            ext_rel  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
            pd_rel   = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 3, TMO + 3)
                                                   : $urandom_range(0, 8);
            abort_at = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 8) : 0;
            run_txn(nz, (NZ*WW)'($urandom), NZ'($urandom), ext_rel, pd_rel,
                    abort_at, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
